// File: rtl/ascon_ti_sbox_fold.sv
// ascon_ti_sbox_fold
//   Folded three-share threshold implementation of the Ascon 5-bit S-box.
//   A 320-bit state (five 64-bit lanes, lane k = row xk at bits [64k+63:64k])
//   is captured as three Boolean shares and processed SLICES columns per cycle.
//   The result is held in registered output shares until the consumer takes it.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (ready only in IDLE)
//   x_s0, x_s1, x_s2      input shares, 320 bits each
//   out_valid / out_ready output handshake (valid only in DONE)
//   y_s0, y_s1, y_s2      output shares, 320 bits each
//   busy                  high while columns are being processed
//   rnd                   only with ASCON_TI_REFRESH_EN: 10*SLICES fresh random
//                         bits per RUN cycle, r_a = rnd[5*SLICES-1:0],
//                         r_b = rnd[10*SLICES-1:5*SLICES], column j row k at 5*j+k
//
// Optional feature macro: ASCON_TI_REFRESH_EN (output share refresh).
//
// FSM states
//   IDLE | waiting for an input state, in_ready high
//   RUN  | one group of SLICES columns per cycle, ascending
//   DONE | result presented, held until out_ready

module ascon_ti_sbox_fold #(
    parameter int SLICES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] x_s0,
    input  logic [319:0] x_s1,
    input  logic [319:0] x_s2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] y_s0,
    output logic [319:0] y_s1,
    output logic [319:0] y_s2,
    output logic         busy
`ifdef ASCON_TI_REFRESH_EN
    ,
    input  logic [10*SLICES-1:0] rnd
`endif
);

    localparam int NCOL = 64 / SLICES;
    localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCOL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [319:0]    xr0, xr1, xr2;
    logic [319:0]    yr0, yr1, yr2;

    logic [5:0]      col [SLICES];
    logic [4:0]      cy0 [SLICES];
    logic [4:0]      cy1 [SLICES];
    logic [4:0]      cy2 [SLICES];

    // Input linear layer of the Ascon S-box; applied to each share alone.
    function automatic logic [4:0] lin_in(input logic [4:0] v);
        logic [4:0] r;
        r    = v;
        r[0] = v[0] ^ v[4];
        r[4] = v[4] ^ v[3];
        r[2] = v[2] ^ v[1];
        return r;
    endfunction

    // Output linear layer; the final inversion of row 2 goes into one share only.
    function automatic logic [4:0] lin_out(input logic [4:0] v, input logic inv);
        logic [4:0] r;
        r    = v;
        r[1] = v[1] ^ v[0];
        r[0] = v[0] ^ v[4];
        r[3] = v[3] ^ v[2];
        r[2] = v[2] ^ inv;
        return r;
    endfunction

    // Shared chi step x_i ^= ~x_{i+1} & x_{i+2}. Output share i is built only
    // from shares i+1 and i+2, including its linear term, so no share function
    // ever sees all three input shares. Bit index = row index.
    function automatic logic [14:0] ti_sbox(input logic [4:0] s0,
                                            input logic [4:0] s1,
                                            input logic [4:0] s2);
        logic [4:0] l0, l1, l2, a0, a1, a2, b0, b1, b2, c0, c1, c2;
        l0 = lin_in(s0);
        l1 = lin_in(s1);
        l2 = lin_in(s2);
        // a[i] = x[i+1] (complemented through share 0), b[i] = x[i+2]
        a0 = ~{l0[0], l0[4:1]};
        a1 =  {l1[0], l1[4:1]};
        a2 =  {l2[0], l2[4:1]};
        b0 =  {l0[1:0], l0[4:2]};
        b1 =  {l1[1:0], l1[4:2]};
        b2 =  {l2[1:0], l2[4:2]};
        c0 = l1 ^ (a1 & b1) ^ (a1 & b2) ^ (a2 & b1);
        c1 = l2 ^ (a2 & b2) ^ (a2 & b0) ^ (a0 & b2);
        c2 = l0 ^ (a0 & b0) ^ (a0 & b1) ^ (a1 & b0);
        return {lin_out(c2, 1'b0), lin_out(c1, 1'b0), lin_out(c0, 1'b1)};
    endfunction

    always_comb begin
        logic [4:0]  g0, g1, g2;
        logic [14:0] res;
        g0  = '0;
        g1  = '0;
        g2  = '0;
        res = '0;
        for (int j = 0; j < SLICES; j++) begin
            col[j] = 6'(int'(cnt) * SLICES + j);
            for (int k = 0; k < 5; k++) begin
                g0[k] = xr0[{3'(k), col[j]}];
                g1[k] = xr1[{3'(k), col[j]}];
                g2[k] = xr2[{3'(k), col[j]}];
            end
            res = ti_sbox(g0, g1, g2);
`ifdef ASCON_TI_REFRESH_EN
            cy0[j] = res[4:0]   ^ rnd[5*j +: 5];
            cy1[j] = res[9:5]   ^ rnd[5*SLICES + 5*j +: 5];
            cy2[j] = res[14:10] ^ rnd[5*j +: 5] ^ rnd[5*SLICES + 5*j +: 5];
`else
            cy0[j] = res[4:0];
            cy1[j] = res[9:5];
            cy2[j] = res[14:10];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            xr0       <= '0;
            xr1       <= '0;
            xr2       <= '0;
            yr0       <= '0;
            yr1       <= '0;
            yr2       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr0      <= x_s0;
                        xr1      <= x_s1;
                        xr2      <= x_s2;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int j = 0; j < SLICES; j++) begin
                        for (int k = 0; k < 5; k++) begin
                            yr0[{3'(k), col[j]}] <= cy0[j][k];
                            yr1[{3'(k), col[j]}] <= cy1[j][k];
                            yr2[{3'(k), col[j]}] <= cy2[j][k];
                        end
                    end
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // A pending in_valid waits for IDLE; jobs never overlap.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign y_s0 = yr0;
    assign y_s1 = yr1;
    assign y_s2 = yr2;

endmodule

// File: tb/tb_ascon_ti_sbox_fold.sv
module tb_ascon_ti_sbox_fold;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   iv  = '0;
    logic [2:0]   orr = '1;
    logic [319:0] xs0 = '0, xs1 = '0, xs2 = '0;
    wire  [2:0]   ir, ov, bz;
    wire  [319:0] y0 [3];
    wire  [319:0] y1 [3];
    wire  [319:0] y2 [3];
`ifdef ASCON_TI_REFRESH_EN
    logic [79:0]  rnd8  = '0;
    logic [9:0]   rnd1  = '0;
    logic [639:0] rnd64 = '0;
`endif

    always #5 clk = ~clk;

    ascon_ti_sbox_fold #(.SLICES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .x_s0(xs0), .x_s1(xs1), .x_s2(xs2),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .y_s0(y0[0]), .y_s1(y1[0]), .y_s2(y2[0]), .busy(bz[0])
`ifdef ASCON_TI_REFRESH_EN
        , .rnd(rnd8)
`endif
    );

    ascon_ti_sbox_fold #(.SLICES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .x_s0(xs0), .x_s1(xs1), .x_s2(xs2),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .y_s0(y0[1]), .y_s1(y1[1]), .y_s2(y2[1]), .busy(bz[1])
`ifdef ASCON_TI_REFRESH_EN
        , .rnd(rnd1)
`endif
    );

    ascon_ti_sbox_fold #(.SLICES(64)) u_s64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .x_s0(xs0), .x_s1(xs1), .x_s2(xs2),
        .out_valid(ov[2]), .out_ready(orr[2]),
        .y_s0(y0[2]), .y_s1(y1[2]), .y_s2(y2[2]), .busy(bz[2])
`ifdef ASCON_TI_REFRESH_EN
        , .rnd(rnd64)
`endif
    );

    // Hand-entered Ascon S-box table, index = {x0,x1,x2,x3,x4}.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    localparam int LAT [3] = '{8, 64, 1};

    typedef struct {
        int           d;
        logic [319:0] exp;
        int           t;
    } job_t;

    job_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [319:0] golden(input logic [319:0] x);
        logic [319:0] y;
        logic [4:0]   v, s;
        logic [8:0]   ix;
        y = '0;
        for (int c = 0; c < 64; c++) begin
            for (int k = 0; k < 5; k++) begin
                ix = 9'(64 * k + c);
                v[4-k] = x[ix];
            end
            s = SBOX[v];
            for (int k = 0; k < 5; k++) begin
                ix = 9'(64 * k + c);
                y[ix] = s[4-k];
            end
        end
        return y;
    endfunction

    function automatic logic [319:0] lanes(input logic [4:0] m);
        logic [319:0] r;
        for (int k = 0; k < 5; k++) r[64*k +: 64] = {64{m[k]}};
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk_v(input string name, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each rising out_valid.
    logic [2:0] ov_prev = '0;
    job_t       mj;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d] && !ov_prev[d]) begin
                if (sb.size() == 0) begin
                    chk_i("unexpected_out_valid", d, -1);
                end else begin
                    mj = sb.pop_front();
                    chk_i("out_dut", d, mj.d);
                    chk_v("share_xor", y0[d] ^ y1[d] ^ y2[d], mj.exp);
                    chk_i("latency", cyc - mj.t, LAT[d]);
                end
            end
        end
        ov_prev = ov;
    end

    task automatic issue(input int d, input logic [319:0] a, input logic [319:0] b,
                         input logic [319:0] c, input bit track);
        int n = 0;
        @(negedge clk);
        while (!ir[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir[d]) chk_i("in_ready_timeout", 0, 1);
        xs0 = a; xs1 = b; xs2 = c;
        iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        if (track) sb.push_back('{d, golden(a ^ b ^ c), cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk_i("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ov(input int d);
        int n = 0;
        while (!ov[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ov[d]) chk_i("out_valid_timeout", 0, 1);
    endtask

    initial begin : main
        logic [319:0] a, b, c, m1, m2, s0, s1, s2;
        bit stable, held, ir_seen, ov_seen;
`ifdef ASCON_TI_REFRESH_EN
        logic [319:0] r0, r1, r2;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk_i("rst_in_ready", int'(ir), 7);
        chk_i("rst_out_valid", int'(ov), 0);
        chk_i("rst_busy", int'(bz), 0);
        chk_v("rst_y_s0", y0[0], '0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero shares: share XOR = S(0)=0x04 on every column -> lane 2 ones
        issue(0, '0, '0, '0, 1);
        drain();
        chk_v("zero_lanes", y0[0] ^ y1[0] ^ y2[0], lanes(5'b00100));

        // Value 1 per column (lane 4 ones), masked pairwise: S(1)=0x0B
        m1 = rand320();
        m2 = rand320();
        issue(0, lanes(5'b10000) ^ m1, m1 ^ m2, m2, 1);
        drain();
        chk_v("one_lanes", y0[0] ^ y1[0] ^ y2[0], lanes(5'b11010));

        // Random states
        for (int i = 0; i < 2; i++) begin
            issue(0, rand320(), rand320(), rand320(), 1);
            drain();
        end

        // Back-pressure: DONE held 20 cycles, in_valid ignored there
        orr[0] = 1'b0;
        a = rand320(); b = rand320(); c = rand320();
        issue(0, a, b, c, 1);
        wait_ov(0);
        s0 = y0[0]; s1 = y1[0]; s2 = y2[0];
        stable = 1; held = 1; ir_seen = 0;
        a = rand320(); b = rand320(); c = rand320();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                xs0 = a; xs1 = b; xs2 = c;
                iv[0] = 1'b1;
            end
            @(negedge clk);
            if (y0[0] !== s0 || y1[0] !== s1 || y2[0] !== s2) stable = 0;
            if (!ov[0]) held = 0;
            if (ir[0]) ir_seen = 1;
        end
        chk_i("hold_y_stable", int'(stable), 1);
        chk_i("hold_out_valid", int'(held), 1);
        chk_i("hold_in_ready", int'(ir_seen), 0);
        orr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk_i("release_in_ready", int'(ir[0]), 1);
        chk_i("release_busy", int'(bz[0]), 0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        sb.push_back('{0, golden(a ^ b ^ c), cyc});
        chk_i("accept_next_busy", int'(bz[0]), 1);
        drain();

        // Reset in the middle of RUN aborts the job
        issue(0, rand320(), rand320(), rand320(), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        iv[0] = 1'b1;
        #1;
        chk_i("abort_out_valid", int'(ov[0]), 0);
        chk_i("abort_in_ready", int'(ir[0]), 1);
        chk_i("abort_busy", int'(bz[0]), 0);
        chk_v("abort_y", y0[0] | y1[0] | y2[0], '0);
        @(negedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ov[0] || bz[0]) ov_seen = 1;
        end
        chk_i("abort_no_output", int'(ov_seen), 0);
        issue(0, rand320(), rand320(), rand320(), 1);
        drain();

        // Fold extremes
        issue(1, rand320(), rand320(), rand320(), 1);
        drain();
        issue(2, rand320(), rand320(), rand320(), 1);
        drain();

`ifdef ASCON_TI_REFRESH_EN
        a = rand320(); b = rand320(); c = rand320();
        for (int i = 0; i < 10; i++) rnd8[8*i +: 8] = 8'($urandom());
        issue(0, a, b, c, 1);
        wait_ov(0);
        r0 = y0[0]; r1 = y1[0]; r2 = y2[0];
        drain();
        rnd8 = '0;
        issue(0, a, b, c, 1);
        wait_ov(0);
        chk_i("refresh_share_differs", int'((r0 != y0[0]) && (r1 != y1[0])), 1);
        chk_v("refresh_xor_same", r0 ^ r1 ^ r2, y0[0] ^ y1[0] ^ y2[0]);
        drain();
`endif

        chk_i("final_pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
